// File: rtl/lsu_bus_master_if.sv
//------------------------------------------------------------------------------
// Module      : lsu_bus_master_if
// Description : Operation encoding plus the pipeline/write-back/data-bus
//               signal bundle of the load/store bus master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package lsu_bus_master_pkg;
  // Codes 8..15 are not memory operations.
  typedef enum logic [3:0] {
    OP_LB   = 4'd0,
    OP_LH   = 4'd1,
    OP_LW   = 4'd2,
    OP_LBU  = 4'd3,
    OP_LHU  = 4'd4,
    OP_SB   = 4'd5,
    OP_SH   = 4'd6,
    OP_SW   = 4'd7,
    OP_NONE = 4'd15
  } operation_e;
endpackage

interface lsu_bus_master_if #(
  parameter int XLEN = 32
);
  // pipeline request
  logic                            req_valid_i;
  logic                            req_ready_o;
  lsu_bus_master_pkg::operation_e  operation_i;
  logic [XLEN-1:0]                 addr_i;
  logic [XLEN-1:0]                 wdata_i;
  logic [4:0]                      rd_addr_i;
  // register-file write-back
  logic [4:0]                      rf_addr_o;
  logic                            rf_write_enable_o;
  logic [XLEN-1:0]                 rf_data_o;
  // data-memory bus
  logic                            bus_req_o;
  logic                            bus_gnt_i;
  logic [XLEN-1:0]                 bus_addr_o;
  logic                            bus_we_o;
  logic [3:0]                      bus_be_o;
  logic [XLEN-1:0]                 bus_wdata_o;
  logic                            bus_rvalid_i;
  logic [XLEN-1:0]                 bus_rdata_i;

  // the load/store unit side
  modport master (
    input  req_valid_i, operation_i, addr_i, wdata_i, rd_addr_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output req_ready_o, rf_addr_o, rf_write_enable_o, rf_data_o,
    output bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o
  );

  // the pipeline and memory side
  modport slave (
    output req_valid_i, operation_i, addr_i, wdata_i, rd_addr_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  req_ready_o, rf_addr_o, rf_write_enable_o, rf_data_o,
    input  bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o
  );
endinterface

`default_nettype wire

// File: rtl/lsu_bus_master.sv
//------------------------------------------------------------------------------
// Module      : lsu_bus_master
// Description : Load/store unit issuing byte-lane transactions on a
//               request/grant/response bus. Word-crossing accesses are split
//               into two transactions; loads are extended and written back.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  lsu_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e          state;
  operation_e      op;
  logic [XLEN-1:0] word_addr;
  logic [1:0]      offset;
  logic [3:0]      be_hi;      // nonzero means a second transaction is needed
  logic [XLEN-1:0] wdata_hi;
  logic [4:0]      rd;
  logic [XLEN-1:0] rdata_lo;

  logic            in_is_mem;
  logic            in_is_store;
  logic [7:0]      lane_mask;
  logic [63:0]     wr_window;
  logic            op_is_load;
  logic            op_is_store;
  logic            resp_last;
  logic [XLEN-1:0] lo_word;
  logic [23:0]     hi_bytes;
  logic [XLEN-1:0] load_data;

  // Shift the {hi,lo} pair down by the byte offset and extend by op.
  // Only hi[23:0] can ever reach the 32-bit result.
  function automatic logic [31:0] extend(operation_e o, logic [1:0] off,
                                         logic [23:0] hi, logic [31:0] lo);
    logic [31:0] r;
    case (off)
      2'd0:    r = lo;
      2'd1:    r = {hi[7:0],  lo[31:8]};
      2'd2:    r = {hi[15:0], lo[31:16]};
      default: r = {hi[23:0], lo[31:24]};
    endcase
    case (o)
      OP_LB:   return {{24{r[7]}}, r[7:0]};
      OP_LH:   return {{16{r[15]}}, r[15:0]};
      OP_LBU:  return {24'b0, r[7:0]};
      OP_LHU:  return {16'b0, r[15:0]};
      default: return r;
    endcase
  endfunction

  // Decode the incoming request into lane mask and lane-aligned write window.
  always_comb begin
    in_is_mem   = bus.operation_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                                          OP_SB, OP_SH, OP_SW};
    in_is_store = bus.operation_i inside {OP_SB, OP_SH, OP_SW};
    case (bus.operation_i)
      OP_LB, OP_LBU, OP_SB: lane_mask = 8'b0000_0001;
      OP_LH, OP_LHU, OP_SH: lane_mask = 8'b0000_0011;
      default:              lane_mask = 8'b0000_1111;
    endcase
    lane_mask = lane_mask << bus.addr_i[1:0];
    wr_window = {32'b0, bus.wdata_i} << {bus.addr_i[1:0], 3'b000};
  end

  // Assemble the load result from the response that completes the access.
  always_comb begin
    op_is_load  = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    op_is_store = op inside {OP_SB, OP_SH, OP_SW};
    resp_last   = 1'b0;
    lo_word     = rdata_lo;
    hi_bytes    = 24'b0;
    if (state == S_WAIT0) begin
      lo_word   = bus.bus_rdata_i;
      resp_last = bus.bus_rvalid_i && (be_hi == 4'b0);
    end else if (state == S_WAIT1) begin
      hi_bytes  = bus.bus_rdata_i[23:0];
      resp_last = bus.bus_rvalid_i;
    end
    load_data = extend(op, offset, hi_bytes, lo_word);
  end

  // Control FSM with registered bus and write-back outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state                 <= S_IDLE;
      op                    <= OP_LB;
      word_addr             <= '0;
      offset                <= 2'b0;
      be_hi                 <= 4'b0;
      wdata_hi              <= '0;
      rd                    <= 5'b0;
      rdata_lo              <= '0;
      bus.req_ready_o       <= 1'b1;
      bus.bus_req_o         <= 1'b0;
      bus.bus_addr_o        <= '0;
      bus.bus_we_o          <= 1'b0;
      bus.bus_be_o          <= 4'b0;
      bus.bus_wdata_o       <= '0;
      bus.rf_addr_o         <= 5'b0;
      bus.rf_write_enable_o <= 1'b0;
      bus.rf_data_o         <= '0;
    end else begin
      bus.rf_write_enable_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid_i && in_is_mem) begin
            op              <= bus.operation_i;
            word_addr       <= {bus.addr_i[XLEN-1:2], 2'b00};
            offset          <= bus.addr_i[1:0];
            be_hi           <= lane_mask[7:4];
            wdata_hi        <= wr_window[63:32];
            rd              <= bus.rd_addr_i;
            bus.req_ready_o <= 1'b0;
            bus.bus_req_o   <= 1'b1;
            bus.bus_addr_o  <= {bus.addr_i[XLEN-1:2], 2'b00};
            bus.bus_be_o    <= lane_mask[3:0];
            bus.bus_we_o    <= in_is_store;
            bus.bus_wdata_o <= wr_window[31:0];
            state           <= S_REQ0;
          end
        end
        S_REQ0, S_REQ1: begin
          if (bus.bus_gnt_i) begin
            bus.bus_req_o   <= 1'b0;
            bus.bus_addr_o  <= '0;
            bus.bus_be_o    <= 4'b0;
            bus.bus_we_o    <= 1'b0;
            bus.bus_wdata_o <= '0;
            state           <= (state == S_REQ0) ? S_WAIT0 : S_WAIT1;
          end
        end
        S_WAIT0, S_WAIT1: begin
          if (bus.bus_rvalid_i) begin
            if (state == S_WAIT0) rdata_lo <= bus.bus_rdata_i;
            if (resp_last) begin
              if (op_is_load) begin
                bus.rf_addr_o         <= rd;
                bus.rf_data_o         <= load_data;
                bus.rf_write_enable_o <= (rd != 5'b0);
              end
              state <= S_DONE;
            end else begin
              // word address + 4 wraps naturally at the top of the space
              bus.bus_req_o   <= 1'b1;
              bus.bus_addr_o  <= word_addr + XLEN'(4);
              bus.bus_be_o    <= be_hi;
              bus.bus_we_o    <= op_is_store;
              bus.bus_wdata_o <= wdata_hi;
              state           <= S_REQ1;
            end
          end
        end
        S_DONE: begin
          bus.req_ready_o <= 1'b1;
          state           <= S_IDLE;
        end
        default: begin
          bus.req_ready_o <= 1'b1;
          state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
Load/store unit that initiates data-memory accesses over a request/grant/response bus, replacing direct array access in the memory stage. It takes one load/store operation from the pipeline, drives byte-lane transactions to an external data memory, and returns sign- or zero-extended load data with the write-back register address. Accesses that cross a 32-bit word boundary are split into two sequential bus transactions.

Parameters:
XLEN, 32, data and address width; the block supports only 32.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  1  pipeline presents a load/store
req_ready_o  out  1  block accepts the request this cycle
operation_i  in  operation_e  LB/LH/LW/LBU/LHU/SB/SH/SW; any other value is not a memory op
addr_i  in  XLEN  byte address
wdata_i  in  XLEN  store data, right-aligned
rd_addr_i  in  5  load destination register
rf_addr_o  out  5  write-back register address
rf_write_enable_o  out  1  write-back strobe
rf_data_o  out  XLEN  extended load result
bus_req_o  out  1  bus request
bus_gnt_i  in  1  request accepted
bus_addr_o  out  XLEN  word-aligned address
bus_we_o  out  1  1 = write
bus_be_o  out  4  byte enables
bus_wdata_o  out  XLEN  lane-aligned write data
bus_rvalid_i  in  1  response valid; asserted for reads and writes
bus_rdata_i  in  XLEN  read data

Behaviour:
- Interface: one clock `clk_i`. Reset `rst_i` is asynchronous and active-high.
- Reset value of every register and output is 0, except `req_ready_o`, which is 1 because the FSM resets to IDLE.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE: `req_ready_o` = 1. When `req_valid_i` is high with a memory op, capture op, addr, wdata and rd, then go to REQ0. A non-memory op is ignored and the FSM stays in IDLE.
- `req_ready_o` = 0 in every state except IDLE. Upstream holds its request while ready is low.
- Size n = 1/2/4 for byte/half/word. Offset o = addr[1:0].
- Lane mask (8 bits) = ((1<<n)-1)<<o. be0 = mask[3:0], be1 = mask[7:4]. The access is split when be1 != 0.
- Write window (64 bits) = {32'b0, wdata} << (8*o). Transaction 0 carries the low word; transaction 1 carries the high word.
- REQ0: `bus_req_o` = 1, `bus_addr_o` = {addr[31:2], 2'b00}, `bus_be_o` = be0, `bus_we_o` = 1 for stores, `bus_wdata_o` = low window word.
  - These outputs are held stable until `bus_gnt_i`.
  - On grant go to WAIT0; `bus_req_o` is low in the next cycle.
- WAIT0: on `bus_rvalid_i`, capture `bus_rdata_i` as lo. Go to REQ1 if split, else DONE.
- REQ1: as REQ0 but with address = word address + 4 (wraps modulo 2^32), `bus_be_o` = be1, `bus_wdata_o` = high window word. On grant go to WAIT1.
- WAIT1: on `bus_rvalid_i`, capture hi and go to DONE.
- `bus_rvalid_i` outside WAIT0/WAIT1 is ignored. The bus never returns rvalid in the same cycle as gnt.
- Load result:
  - Form r = ({hi, lo} >> (8*o))[31:0]; hi = 0 when not split.
  - LB/LH sign-extend r[7:0]/r[15:0]. LBU/LHU zero-extend. LW takes r as is.
- DONE lasts exactly one cycle, then returns to IDLE.
  - For a load, `rf_write_enable_o` = 1 for that single cycle only (0 if rd = 0), with `rf_addr_o` and `rf_data_o` valid in the same cycle.
  - For a store, `rf_write_enable_o` stays 0.
- `rf_data_o` and `rf_addr_o` hold their last values outside DONE. `rf_write_enable_o` is 0 outside DONE.
- Minimum latency, with grant in the REQ cycle and rvalid one cycle later: accept at cycle 0, REQ0 at 1, WAIT0 at 2, DONE at 3. A split access adds 2 cycles. `req_ready_o` is high again at cycle 4.
- Reset mid-operation: the FSM returns to IDLE immediately and all bus outputs and `rf_write_enable_o` drop to 0. No write-back occurs for the aborted op. A response arriving after reset is ignored.

Test Plan:
- SW 0xDEADBEEF at 0x100, grant immediate, rvalid next cycle -> one transaction: addr 0x100, be 1111, we = 1, wdata 0xDEADBEEF; no rf write; ready high 4 cycles after accept.
- LB at 0x103 with rdata 0x80123456 -> be 1000, `rf_data_o` 0xFFFFFF80, one-cycle `rf_write_enable_o` with `rf_addr_o` = rd. Repeat as LBU -> 0x00000080.
- LW at 0x102 -> tx0 addr 0x100 be 1100, rdata 0x55667788; tx1 addr 0x104 be 0011, rdata 0x11223344 -> `rf_data_o` 0x33445566.
- SH 0xABCD at 0x203 -> tx0 addr 0x200 be 1000, wdata[31:24] = 0xCD; tx1 addr 0x204 be 0001, wdata[7:0] = 0xAB; no rf write.
- LH at 0x10 with grant delayed 3 cycles -> `bus_req_o`, addr, be and we held constant for 4 cycles; `req_ready_o` low throughout; result correct.
- Assert `rst_i` during WAIT0 of an LW, then drive rvalid after reset -> all outputs 0 at once, no `rf_write_enable_o`, rvalid ignored; the next SW completes normally.
